// File: rtl/haar_cascade_controller_if.sv
// Handshake and data bus between the cascade controller, the stage table,
// the window producer and the classifier datapath.
interface haar_cascade_controller_if #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH_8  = 8,
  parameter int DATA_WIDTH_12 = 12,
  parameter int DATA_WIDTH_16 = 16
);
  logic                     i_window_valid;
  logic                     o_window_ready;
  logic [ADDR_WIDTH-1:0]    o_stage_addr;
  logic [DATA_WIDTH_8-1:0]  i_stage_num_classifier;
  logic [DATA_WIDTH_16-1:0] i_stage_threshold;
  logic                     o_classifier_start;
  logic [ADDR_WIDTH-1:0]    o_classifier_index;
  logic                     i_classifier_done;
  logic [DATA_WIDTH_12-1:0] i_haar_value;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_is_candidate;
  logic [DATA_WIDTH_8-1:0]  o_reject_stage;

  modport master (
    input  i_window_valid, i_stage_num_classifier, i_stage_threshold,
           i_classifier_done, i_haar_value,
    output o_window_ready, o_stage_addr, o_classifier_start, o_classifier_index,
           o_busy, o_done, o_is_candidate, o_reject_stage
  );

  modport slave (
    output i_window_valid, i_stage_num_classifier, i_stage_threshold,
           i_classifier_done, i_haar_value,
    input  o_window_ready, o_stage_addr, o_classifier_start, o_classifier_index,
           o_busy, o_done, o_is_candidate, o_reject_stage
  );
endinterface

// File: rtl/haar_cascade_controller.sv
// Walks one integral window through every cascade stage, summing classifier
// results per stage and stopping at the first stage whose sum misses threshold.
module haar_cascade_controller #(
  parameter int NUM_STAGES    = 25,
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH_8  = 8,
  parameter int DATA_WIDTH_12 = 12,
  parameter int DATA_WIDTH_16 = 16
) (
  input  logic                      clk_fpga,
  input  logic                      reset_fpga,
  haar_cascade_controller_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_EVAL, S_DONE
  } state_t;

  localparam logic [DATA_WIDTH_16-1:0] ACC_MAX = {1'b0, {(DATA_WIDTH_16-1){1'b1}}};
  localparam logic [DATA_WIDTH_16-1:0] ACC_MIN = {1'b1, {(DATA_WIDTH_16-1){1'b0}}};

  state_t                   state_q, state_d;
  logic [DATA_WIDTH_8-1:0]  stage_q;
  logic [DATA_WIDTH_8-1:0]  k_q;
  logic [DATA_WIDTH_8-1:0]  cnt_q;
  logic [ADDR_WIDTH-1:0]    cls_idx_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH_16-1:0] acc_q;
  logic [DATA_WIDTH_16-1:0] thr_q;
  logic                     cand_q;
  logic [DATA_WIDTH_8-1:0]  rej_q;

  logic [DATA_WIDTH_16:0]   sum_ext;
  logic [DATA_WIDTH_16-1:0] acc_sat;
  logic                     pass;
  logic                     last_stage;

  // One guard bit is enough to detect overflow of a 16 + 12 bit signed add.
  always_comb begin
    sum_ext = {acc_q[DATA_WIDTH_16-1], acc_q}
            + {{(DATA_WIDTH_16+1-DATA_WIDTH_12){bus.i_haar_value[DATA_WIDTH_12-1]}},
               bus.i_haar_value};
    acc_sat = sum_ext[DATA_WIDTH_16-1:0];
    if (sum_ext[DATA_WIDTH_16:DATA_WIDTH_16-1] == 2'b01) acc_sat = ACC_MAX;
    if (sum_ext[DATA_WIDTH_16:DATA_WIDTH_16-1] == 2'b10) acc_sat = ACC_MIN;
  end

  assign pass       = $signed(acc_q) >= $signed(thr_q);
  assign last_stage = (stage_q == DATA_WIDTH_8'(NUM_STAGES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.i_window_valid) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = (bus.i_stage_num_classifier == '0) ? S_EVAL : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (bus.i_classifier_done)
                 state_d = (k_q + 1'b1 == cnt_q) ? S_EVAL : S_ISSUE;
      S_EVAL:  state_d = (!pass || last_stage) ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      cls_idx_q <= '0;
      addr_q    <= '0;
      acc_q     <= '0;
      thr_q     <= '0;
      cand_q    <= 1'b0;
      rej_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: if (bus.i_window_valid) begin
          stage_q   <= '0;
          cls_idx_q <= '0;
          acc_q     <= '0;
        end
        S_FETCH: addr_q <= ADDR_WIDTH'(stage_q);
        S_LOAD: begin
          cnt_q <= bus.i_stage_num_classifier;
          thr_q <= bus.i_stage_threshold;
          acc_q <= '0;
          k_q   <= '0;
        end
        S_WAIT: if (bus.i_classifier_done) begin
          acc_q     <= acc_sat;
          cls_idx_q <= cls_idx_q + 1'b1;
          k_q       <= k_q + 1'b1;
        end
        // Verdict lands at the EVAL edge so it is stable alongside o_done.
        S_EVAL: begin
          if (!pass) begin
            cand_q <= 1'b0;
            rej_q  <= stage_q;
          end else if (last_stage) begin
            cand_q <= 1'b1;
            rej_q  <= DATA_WIDTH_8'(NUM_STAGES);
          end else begin
            stage_q <= stage_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Address is live during FETCH so table data is valid in LOAD.
  assign bus.o_stage_addr       = (state_q == S_FETCH) ? ADDR_WIDTH'(stage_q) : addr_q;
  assign bus.o_window_ready     = (state_q == S_IDLE);
  assign bus.o_busy             = (state_q != S_IDLE);
  assign bus.o_done             = (state_q == S_DONE);
  assign bus.o_classifier_start = (state_q == S_ISSUE);
  assign bus.o_classifier_index = cls_idx_q;
  assign bus.o_is_candidate     = cand_q;
  assign bus.o_reject_stage     = rej_q;
endmodule
